// File: rtl/adc_peak_meter.sv
// Windowed min/max tracker on an offset-binary ADC stream with a multi-cycle
// converter that reports each window's peak amplitude in millivolts.
module adc_peak_meter #(
    parameter int DATA_W        = 14,
    parameter int MID_CODE      = 8191,
    parameter int FULL_SCALE_MV = 3080,
    parameter int MIN_WIN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [15:0]       win_len,
    output logic [11:0]       peak_mv,
    output logic [DATA_W-1:0] max_code,
    output logic [DATA_W-1:0] min_code,
    output logic              meas_valid,
    output logic              busy
);

    localparam int NUM_W = 26;
    localparam int DIV_W = DATA_W + 1;
    localparam int OUT_W = 12;
    localparam logic [NUM_W-1:0] FS_MV   = NUM_W'(FULL_SCALE_MV);
    localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(2 * MID_CODE);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] w);
        return (w < 16'(MIN_WIN)) ? 16'(MIN_WIN) : w;
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic [NUM_W-1:0] q);
        return (q > NUM_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
    endfunction

    logic [15:0]       cnt_q, len_q, cur_len;
    logic [DATA_W-1:0] run_max_q, run_min_q, hold_max_q, hold_min_q;
    logic [DATA_W-1:0] new_max, new_min;
    logic              snap_q, first, last;

    always_comb begin
        first   = (cnt_q == 16'd0);
        cur_len = first ? clamp_len(win_len) : len_q;
        last    = sample_valid && (cnt_q == cur_len - 16'd1);
        new_max = (first || sample_in > run_max_q) ? sample_in : run_max_q;
        new_min = (first || sample_in < run_min_q) ? sample_in : run_min_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            len_q      <= 16'(MIN_WIN);
            run_max_q  <= '0;
            run_min_q  <= '1;
            hold_max_q <= '0;
            hold_min_q <= '0;
            snap_q     <= 1'b0;
        end else begin
            snap_q <= last;
            if (sample_valid) begin
                run_max_q <= new_max;
                run_min_q <= new_min;
                if (first) len_q <= cur_len;
                if (last) begin
                    cnt_q      <= '0;
                    hold_max_q <= new_max;
                    hold_min_q <= new_min;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    // Conversion: multiply once, then one restoring-divide quotient bit per cycle
    state_t            state_q, state_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [DIV_W-1:0]  rem_q, rem_d, trial, diff;
    logic [4:0]        bit_q, bit_d;
    logic              ge, load_out;
    logic [OUT_W-1:0]  peak_q;
    logic [DATA_W-1:0] max_q, min_q;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        rem_d    = rem_q;
        bit_d    = bit_q;
        load_out = 1'b0;
        trial    = {rem_q[DIV_W-2:0], num_q[NUM_W-1]};
        ge       = (trial >= DIVISOR);
        diff     = trial - DIVISOR;
        case (state_q)
            IDLE: if (snap_q) state_d = MUL;
            MUL: begin
                num_d   = NUM_W'(hold_max_q - hold_min_q) * FS_MV;
                rem_d   = '0;
                bit_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                rem_d = ge ? diff : trial;
                num_d = {num_q[NUM_W-2:0], ge};
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'(NUM_W - 1)) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        num_q <= num_d;
        rem_q <= rem_d;
        bit_q <= bit_d;
        if (rst) begin
            state_q <= IDLE;
            peak_q  <= '0;
            max_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                peak_q <= sat_out(num_d);
                max_q  <= hold_max_q;
                min_q  <= hold_min_q;
            end
        end
    end

    assign peak_mv    = peak_q;
    assign max_code   = max_q;
    assign min_code   = min_q;
    assign meas_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_peak_meter.sv
// Directed bench for adc_peak_meter: window results, latency, gaps, back-to-back and reset abort.
module tb_adc_peak_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] sample_in;
    logic        sample_valid;
    logic [15:0] win_len;
    logic [11:0] peak_mv;
    logic [13:0] max_code, min_code;
    logic        meas_valid, busy;

    int checks = 0;
    int failures = 0;
    int mv_cnt = 0;
    logic [11:0] mv_peak;
    logic [13:0] mv_max, mv_min;
    int res_q[$];

    adc_peak_meter dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .win_len(win_len), .peak_mv(peak_mv), .max_code(max_code), .min_code(min_code),
        .meas_valid(meas_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            mv_cnt  = mv_cnt + 1;
            mv_peak = peak_mv;
            mv_max  = max_code;
            mv_min  = min_code;
            res_q.push_back(int'(peak_mv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] s, input logic v);
        sample_in    = s;
        sample_valid = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input int base, input int pk,
                                input int mx, input int mn);
        repeat (40) tick();
        checks++;
        if (mv_cnt - base !== 1) begin
            failures++; $display("FAIL %s_count got=%0d want=1", name, mv_cnt - base);
        end
        checks++;
        if ({mv_peak, mv_max, mv_min} !== {12'(pk), 14'(mx), 14'(mn)}) begin
            failures++;
            $display("FAIL %s_values got peak=%0d max=%0d min=%0d want peak=%0d max=%0d min=%0d",
                     name, mv_peak, mv_max, mv_min, pk, mx, mn);
        end
        checks++;
        if ({peak_mv, max_code, min_code} !== {12'(pk), 14'(mx), 14'(mn)}) begin
            failures++;
            $display("FAIL %s_held got peak=%0d max=%0d min=%0d want peak=%0d", name,
                     peak_mv, max_code, min_code, pk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; sample_in = '0; win_len = '0;
        repeat (3) tick();
        checks++;
        if ({peak_mv, max_code, min_code, meas_valid, busy} !== '0) begin
            failures++; $display("FAIL reset_in got peak=%0d max=%0d min=%0d mv=%b busy=%b want all 0",
                                 peak_mv, max_code, min_code, meas_valid, busy);
        end
        rst = 1'b0;
        repeat (10) tick();
        checks++;
        if ({peak_mv, max_code, min_code, meas_valid, busy} !== '0 || mv_cnt !== 0) begin
            failures++; $display("FAIL reset_after got peak=%0d busy=%b mv_cnt=%0d want 0",
                                 peak_mv, busy, mv_cnt);
        end
    endtask

    task automatic test_flat();
        int base = mv_cnt;
        win_len = 16'd64;
        for (int i = 0; i < 64; i++) send(14'd8191, 1'b1);
        check_result("flat", base, 0, 8191, 8191);
    endtask

    task automatic test_full_swing();
        int base = mv_cnt;
        win_len = 16'd100;
        for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 14'd0 : 14'd16383, 1'b1);
        check_result("full", base, 3080, 16383, 0);
    endtask

    task automatic test_half_amplitude();
        int base = mv_cnt;
        int s;
        win_len = 16'd256;
        for (int i = 0; i < 256; i++) begin
            s = 8191 + int'(4095.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));
            send(14'(s), 1'b1);
        end
        check_result("half", base, 1539, 12286, 4096);
    endtask

    task automatic test_latency();
        int base = mv_cnt;
        win_len = 16'd5;
        for (int i = 0; i < 32; i++) send(14'(1000 + i * 100), 1'b1);
        checks++;
        if (busy !== 1'b0 || mv_cnt !== base) begin
            failures++; $display("FAIL lat_E busy=%b mv_cnt=%0d want busy=0 mv_cnt=%0d", busy, mv_cnt, base);
        end
        for (int k = 1; k <= 29; k++) begin
            tick();
            checks++;
            if (busy !== (k <= 28) || meas_valid !== (k == 28)) begin
                failures++; $display("FAIL lat_E+%0d got busy=%b mv=%b want busy=%b mv=%b",
                                     k, busy, meas_valid, (k <= 28), (k == 28));
            end
            if (k == 28) begin
                checks++;
                if ({peak_mv, max_code, min_code} !== {12'd582, 14'd4100, 14'd1000}) begin
                    failures++; $display("FAIL lat_values got peak=%0d max=%0d min=%0d want 582/4100/1000",
                                         peak_mv, max_code, min_code);
                end
            end
        end
        checks++;
        if (mv_cnt - base !== 1) begin
            failures++; $display("FAIL lat_count got=%0d want=1", mv_cnt - base);
        end
    endtask

    task automatic test_gaps();
        int base = mv_cnt;
        win_len = 16'd5;
        for (int i = 0; i < 64; i++) begin
            if (i == 20) win_len = 16'd1000;
            if (i % 2 == 0) send((i % 4 == 0) ? 14'd5000 : 14'd5500, 1'b1);
            else            send((i % 4 == 1) ? 14'd0 : 14'd16383, 1'b0);
        end
        win_len = 16'd32;
        checks++;
        if (mv_cnt !== base) begin
            failures++; $display("FAIL gaps_early got=%0d results want=0", mv_cnt - base);
        end
        check_result("gaps", base, 94, 5500, 5000);
    endtask

    task automatic test_back_to_back();
        res_q.delete();
        win_len = 16'd32;
        for (int i = 0; i < 64; i++) begin
            if (i < 32) send((i % 2 == 0) ? 14'd7691 : 14'd8691, 1'b1);
            else        send((i % 2 == 0) ? 14'd7191 : 14'd9191, 1'b1);
        end
        repeat (40) tick();
        checks++;
        if (res_q.size() !== 2) begin
            failures++; $display("FAIL b2b_count got=%0d want=2", res_q.size());
        end else begin
            checks++;
            if (res_q[0] !== 188 || res_q[1] !== 376) begin
                failures++; $display("FAIL b2b_values got=%0d,%0d want=188,376", res_q[0], res_q[1]);
            end
        end
        checks++;
        if ({max_code, min_code} !== {14'd9191, 14'd7191}) begin
            failures++; $display("FAIL b2b_codes got max=%0d min=%0d want 9191/7191", max_code, min_code);
        end
    endtask

    task automatic test_reset_mid_conversion();
        int base = mv_cnt;
        win_len = 16'd32;
        for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 14'd0 : 14'd16383, 1'b1);
        repeat (9) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL rstmid_busy got=%b want=1", busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({peak_mv, max_code, min_code, meas_valid, busy} !== '0) begin
            failures++; $display("FAIL rstmid_outputs got peak=%0d max=%0d min=%0d busy=%b want 0",
                                 peak_mv, max_code, min_code, busy);
        end
        rst = 1'b0;
        repeat (40) tick();
        checks++;
        if (mv_cnt !== base || busy !== 1'b0 || peak_mv !== 12'd0) begin
            failures++; $display("FAIL rstmid_after got results=%0d busy=%b peak=%0d want 0",
                                 mv_cnt - base, busy, peak_mv);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_full_swing();
        test_half_amplitude();
        test_latency();
        test_gaps();
        test_back_to_back();
        test_reset_mid_conversion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_peak_meter.md
# adc_peak_meter

Measures the amplitude of a sampled 14-bit offset-binary waveform and reports its peak voltage in millivolts. It is the measurement-side counterpart of the DDS amplitude scaler: the scaler turns a mV target into codes, and this block turns ADC codes back into mV. It sits on the ADC capture path and gives the STM32 closed-loop PID a per-window amplitude reading. It tracks min/max over a programmable sample window, then converts peak-to-peak to mV with a multi-cycle divider while the next window is already being acquired.

## Interface
- DATA_W, 14, sample width (offset binary, mid-scale = 0 V).
- MID_CODE, 8191, mid-scale code; the full-scale deviation from it equals FULL_SCALE_MV.
- FULL_SCALE_MV, 3080, peak mV at full-scale deviation.
- MIN_WIN, 32, minimum effective window length in samples.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  ADC sample.
- sample_valid  in  1  qualifies sample_in for one cycle.
- win_len  in  16  samples per window; sampled at each window start.
- peak_mv  out  12  measured peak voltage, mV; held until next result.
- max_code  out  DATA_W  window maximum; updates with peak_mv.
- min_code  out  DATA_W  window minimum; updates with peak_mv.
- meas_valid  out  1  one-cycle pulse when peak_mv/max_code/min_code update.
- busy  out  1  high while the conversion engine is not idle.

## Operation
- Acquisition runs continuously and is independent of conversion.
  - At window start, the effective length L = max(win_len, MIN_WIN); win_len = 0 also gives MIN_WIN.
  - A counter counts accepted samples.
  - The first sample of a window loads both the running max and the running min; later samples update them by unsigned compare.
- When the L-th sample is accepted:
  - The running max/min are snapshotted into hold registers.
  - The counter clears.
  - The next valid sample starts a new window, even on the very next cycle.
- Conversion FSM has four states:
  - IDLE: waits for a snapshot. Goes to MUL.
  - MUL: registers num = (max − min) × FULL_SCALE_MV as a 26-bit unsigned value. Goes to DIV.
  - DIV: restoring divide of num by 2×MID_CODE (16382), one quotient bit per cycle, 26 cycles. Goes to DONE.
  - DONE: loads the outputs and pulses meas_valid. Goes to IDLE.
- Arithmetic rules:
  - Peak mV = floor(ptp × FULL_SCALE_MV / (2 × MID_CODE)), which equals deviation × FULL_SCALE_MV / MID_CODE.
  - The quotient is saturated to 4095.
  - The remainder is discarded.
- Because L ≥ MIN_WIN and conversion takes fewer than MIN_WIN cycles, a snapshot never arrives while the FSM is busy. No overrun logic is required.

## Timing
- Reset values:
  - peak_mv = 0, max_code = 0, min_code = 0, meas_valid = 0, busy = 0.
  - FSM in IDLE, sample counter = 0, running max = 0, running min = all ones.
- Latency: take the edge that accepts the last sample as edge E.
  - The snapshot is taken at E, and the FSM enters MUL at E+1.
  - DIV covers edges E+2 to E+27; DONE is entered at E+28.
  - meas_valid is high for the cycle following E+28, with all three outputs valid in that same cycle.
- busy is high from E+1 through the DONE cycle inclusive.
- sample_valid low cycles are skipped. A window spans L valid samples regardless of gaps.
- A win_len change mid-window takes effect at the next window start only.
- Reset asserted mid-window or mid-DIV:
  - Aborts the window or conversion.
  - No meas_valid is produced.
  - Outputs return to their reset values on the next edge.
- If the last sample of a window and the first of the next are on consecutive cycles, both are counted correctly: one snapshot, and the new window starts with that sample.

## Test plan
- Reset check: hold rst 3 cycles, then release with sample_valid = 0 → all outputs are 0 and meas_valid never pulses.
- Flat midscale: win_len = 64, 64 samples of 8191 → meas_valid once, peak_mv = 0, max_code = min_code = 8191.
- Full swing: win_len = 100, samples alternating 0 and 16383 → peak_mv = 3080, max_code = 16383, min_code = 0.
- Half amplitude: win_len = 256, sine spanning 4096..12286 → peak_mv = 1539.
- Exact latency, minimum window, and gaps:
  - win_len = 5, so L is clamped to 32; accept the 32nd sample at edge E → meas_valid in the cycle after E+28 and busy high E+1..E+28.
  - With sample_valid toggling 50 %, 32 valid samples still produce exactly one result.
- Back-to-back windows with reset mid-conversion:
  - win_len = 32, continuous valid, amplitudes 1000 and then 2000 codes pk-pk → consecutive results 188 and 376, with no missed window.
  - Assert rst at E+10 → no meas_valid and all outputs 0.
